// File: rtl/node_basic_n.sv
// Leaf node of the computation tree: computes zero / successor / projection on
// operands captured at a start edge and signals completion through RD.
module node_basic_n #(
  parameter int W   = 16,
  parameter int N   = 2,
  parameter int SW  = 1,
  parameter int LAT = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           ST,
  input  logic [1:0]     OP,
  input  logic [SW-1:0]  SEL,
  input  logic [N*W-1:0] IN,
  output logic           RD,
  output logic [W-1:0]   RES,
  output logic           OVF,
  output logic           ERR,
  output logic           BUSY_HIT
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  // PEND: a start edge landed exactly on the completion edge; RD stays high
  // for one cycle before the new operation's busy window opens.
  typedef enum logic [1:0] {IDLE, BUSY, PEND} state_t;

  state_t          state, state_nx;
  logic            st_old;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            rd_nx, hit_nx, capture, complete;
  logic            start_edge;
  logic [W-1:0]    opnd_sel;
  logic            sel_ok;
  logic [1:0]      op_p0;
  logic            ok_p0;
  logic [W-1:0]    opnd_p0;

  // Packs {result, overflow, error} for the captured operation.
  function automatic logic [W+1:0] eval_p0(input logic [1:0] op, input logic ok,
                                           input logic [W-1:0] v);
    logic [W+1:0] r;
    r = '0;
    if (op == 2'd3 || (op != 2'd0 && !ok)) r[0] = 1'b1;
    else if (op == 2'd1) r = {v + W'(1), &v, 1'b0};
    else if (op == 2'd2) r = {v, 2'b00};
    return r;
  endfunction

  assign start_edge = ST & ~st_old;
  assign sel_ok     = int'(SEL) < N;

  always_comb begin
    opnd_sel = '0;
    for (int k = 0; k < N; k++)
      if (SW'(k) == SEL) opnd_sel = IN[k*W +: W];
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rd_nx    = RD;
    hit_nx   = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_edge) begin
          capture  = 1'b1;
          cnt_nx   = CW'(LAT - 1);
          rd_nx    = 1'b0;
          state_nx = BUSY;
        end
      end
      PEND: begin
        hit_nx   = start_edge;
        cnt_nx   = CW'(LAT - 1);
        rd_nx    = 1'b0;
        state_nx = BUSY;
      end
      BUSY: begin
        if (cnt == '0) begin
          complete = 1'b1;
          rd_nx    = 1'b1;
          if (start_edge) begin
            capture  = 1'b1;
            state_nx = PEND;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
          hit_nx = start_edge;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      st_old   <= 1'b1;
      cnt      <= '0;
      RD       <= 1'b1;
      BUSY_HIT <= 1'b0;
    end else begin
      state    <= state_nx;
      st_old   <= ST;
      cnt      <= cnt_nx;
      RD       <= rd_nx;
      BUSY_HIT <= hit_nx;
    end
  end

  // Stage p0: operation capture at the accepted start edge
  always_ff @(posedge CLK) begin
    if (capture) begin
      op_p0   <= OP;
      ok_p0   <= sel_ok;
      opnd_p0 <= opnd_sel;
    end
  end

  // Stage p1: result registers, written only on completion
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RES <= '0;
      OVF <= 1'b0;
      ERR <= 1'b0;
    end else if (complete) begin
      {RES, OVF, ERR} <= eval_p0(op_p0, ok_p0, opnd_p0);
    end
  end

endmodule

// File: tb/tb_node_basic_n.sv
// Scoreboard bench for node_basic_n (W=16, N=4, SW=3, LAT=3): directed cases
// followed by randomized traffic against a behavioural model.
module tb_node_basic_n;
  localparam int W = 16, N = 4, SW = 3, LAT = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ST = 1'b1;
  logic [1:0]    OP = '0;
  logic [SW-1:0] SEL = '0;
  logic [N*W-1:0] IN = '0;
  logic          RD, OVF, ERR, BUSY_HIT;
  logic [W-1:0]  RES;

  node_basic_n #(.W(W), .N(N), .SW(SW), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .ST(ST), .OP(OP), .SEL(SEL), .IN(IN),
    .RD(RD), .RES(RES), .OVF(OVF), .ERR(ERR), .BUSY_HIT(BUSY_HIT)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  logic [17:0] q[$];
  bit   mon_en = 1'b0;
  logic exp_bh = 1'b0;
  logic prev_st = 1'b1;
  int   cyc_n = 0, busy_until = 0;
  logic [63:0] ina = {16'h0004, 16'h0003, 16'hFFFF, 16'h1234};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {result, overflow, error} from the function definitions.
  function automatic logic [17:0] model(input int op, input int sel, input logic [63:0] in);
    int unsigned v;
    if (op == 3 || (op != 0 && sel >= N)) return 18'b1;
    if (op == 0) return 18'b0;
    v = 32'(in >> (16 * sel)) & 32'hFFFF;
    if (op == 1) return {16'((v + 1) % 65536), (v == 65535) ? 1'b1 : 1'b0, 1'b0};
    return {16'(v), 2'b00};
  endfunction

  // One clock: drive inputs, then predict what the sampled edge means.
  task automatic cyc(input logic st, input logic [1:0] op, input logic [SW-1:0] sel,
                     input logic [63:0] in);
    @(negedge CLK);
    ST = st; OP = op; SEL = sel; IN = in;
    @(posedge CLK);
    #1;
    cyc_n++;
    exp_bh = 1'b0;
    if (st && !prev_st) begin
      if (cyc_n < busy_until) exp_bh = 1'b1;
      else begin
        q.push_back(model(int'(op), int'(sel), in));
        busy_until = (cyc_n == busy_until) ? cyc_n + 1 + LAT : cyc_n + LAT;
      end
    end
    prev_st = st;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 2'($urandom), 3'($urandom), {$urandom, $urandom});
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      idle_cyc();
      if (RD) begin ok = 1'b1; break; end
    end
    chk("done_timeout", ok, 1'b1);
  endtask

  // Monitor: pops the scoreboard on each RD rise and checks BUSY_HIT per cycle.
  initial begin
    logic rd_prev = 1'b1;
    int low_n = 0;
    logic [17:0] e;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        rd_prev = RD;
        low_n = 0;
      end else begin
        chk("busy_hit", BUSY_HIT, exp_bh);
        if (!RD) low_n++;
        else if (!rd_prev) begin
          chk("rd_low_len", low_n, LAT);
          if (q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = q.pop_front();
            chk("res", RES, e[17:2]);
            chk("ovf", OVF, e[1]);
            chk("err", ERR, e[0]);
          end
          low_n = 0;
        end
        rd_prev = RD;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rin;
    // Reset held with ST high; release must not start anything.
    repeat (3) @(negedge CLK);
    chk("rst_rd", RD, 1'b1);
    chk("rst_res", RES, 16'h0);
    chk("rst_flags", {OVF, ERR, BUSY_HIT}, 3'b000);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'd2, 3'd0, ina);
      mon_en = 1'b1;
      chk("st_held_rd", RD, 1'b1);
      chk("st_held_res", RES, 16'h0);
    end

    // Projection of operand 0.
    cyc(1'b0, 2'd2, 3'd0, ina);
    cyc(1'b1, 2'd2, 3'd0, ina);
    chk("start_rd_low", RD, 1'b0);
    wait_done();
    chk("proj_res", RES, 16'h1234);
    chk("proj_flags", {OVF, ERR}, 2'b00);

    // Successor with wrap, then without.
    cyc(1'b1, 2'd1, 3'd1, ina);
    wait_done();
    chk("succ_wrap_res", RES, 16'h0000);
    chk("succ_wrap_ovf", OVF, 1'b1);
    cyc(1'b1, 2'd1, 3'd3, ina);
    wait_done();
    chk("succ_res", RES, 16'h0005);
    chk("succ_ovf", OVF, 1'b0);

    // Out-of-range select, then zero.
    cyc(1'b1, 2'd1, 3'd5, ina);
    wait_done();
    chk("badsel_res", RES, 16'h0);
    chk("badsel_err", ERR, 1'b1);
    cyc(1'b1, 2'd0, 3'd5, ina);
    wait_done();
    chk("zero_err", ERR, 1'b0);
    chk("zero_res", RES, 16'h0);

    // Busy hit with operands changing mid-operation.
    cyc(1'b1, 2'd2, 3'd0, ina);
    cyc(1'b0, 2'd2, 3'd1, 64'h1111_2222_3333_4444);
    cyc(1'b1, 2'd1, 3'd2, 64'h5555_6666_7777_8888);
    chk("hit_pulse", BUSY_HIT, 1'b1);
    wait_done();
    chk("hit_res", RES, 16'h1234);

    // Start edge coinciding with completion is accepted after one ready cycle.
    cyc(1'b1, 2'd1, 3'd3, ina);
    cyc(1'b0, 2'd0, 3'd0, ina);
    cyc(1'b0, 2'd0, 3'd0, ina);
    cyc(1'b1, 2'd2, 3'd2, ina);
    chk("coinc_rd", RD, 1'b1);
    chk("coinc_res", RES, 16'h0005);
    idle_cyc();
    chk("coinc_rd_drop", RD, 1'b0);
    wait_done();
    chk("coinc_res2", RES, 16'h0003);

    // Asynchronous reset mid-operation.
    cyc(1'b1, 2'd2, 3'd0, ina);
    idle_cyc();
    @(negedge CLK);
    #2;
    mon_en = 1'b0;
    RST = 1'b0;
    #1;
    chk("async_rd", RD, 1'b1);
    chk("async_res", RES, 16'h0);
    q.delete();
    exp_bh = 1'b0; prev_st = 1'b1; busy_until = 0;
    @(negedge CLK);
    ST = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle_cyc();
      mon_en = 1'b1;
      chk("post_rst_idle", RD, 1'b1);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rin = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) rin = '1;
      cyc(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 2'($urandom), 3'($urandom), rin);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) idle_cyc();
    repeat (2) idle_cyc();
    chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
